// File: rtl/y86_pkg.sv
// Shared Y-86 encodings for the writeback/PC-update block: icodes, register
// indices, status codes, FSM states and the per-cycle status classifier.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } state_t;

    // Address faults outrank illegal instructions, which outrank halt.
    function automatic stat_t classify(input logic imem_err, input logic dmem_err,
                                       input logic instr_valid, input logic [3:0] icode);
        if (imem_err || dmem_err)  return SADR;
        else if (!instr_valid)     return SINS;
        else if (icode == IHALT)   return SHLT;
        else                       return SAOK;
    endfunction

endpackage

// File: rtl/writeback_pc_update_if.sv
// Bundle between the memory/decode side and the writeback/PC-update stage.
interface writeback_pc_update_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic [3:0]       icode;
    logic             cnd;
    logic             instr_valid;
    logic             imem_error;
    logic             dmem_error;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [63:0]      valE;
    logic [63:0]      valM;
    logic [63:0]      valC;
    logic [63:0]      valP;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [63:0]      valA;
    logic [63:0]      valB;
    logic [63:0]      pc;
    logic [2:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output en, icode, cnd, instr_valid, imem_error, dmem_error,
               dstE, dstM, valE, valM, valC, valP, srcA, srcB,
        input  valA, valB, pc, stat, halted, cycle_count, retire_count
    );

    modport slave (
        input  en, icode, cnd, instr_valid, imem_error, dmem_error,
               dstE, dstM, valE, valM, valC, valP, srcA, srcB,
        output valA, valB, pc, stat, halted, cycle_count, retire_count
    );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y-86 register file: two combinational read ports, two write
// ports sharing one enable, port M overriding port E on a common index.
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [3:0]  i_dst_e,
    input  logic [3:0]  i_dst_m,
    input  logic [63:0] i_val_e,
    input  logic [63:0] i_val_m,
    input  logic [3:0]  i_src_a,
    input  logic [3:0]  i_src_b,
    output logic [63:0] o_val_a,
    output logic [63:0] o_val_b
);

    logic [63:0] r_regs [15];
    logic [63:0] w_rd   [16];

    // Index F has no storage, so it can never be written and reads as zero.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_regs[gi] <= '0;
                end else if (i_we) begin
                    if (i_dst_m == 4'(gi))
                        r_regs[gi] <= i_val_m;
                    else if (i_dst_e == 4'(gi))
                        r_regs[gi] <= i_val_e;
                end
            end
            assign w_rd[gi] = r_regs[gi];
        end
    endgenerate

    assign w_rd[RNONE] = '0;
    assign o_val_a     = w_rd[i_src_a];
    assign o_val_b     = w_rd[i_src_b];

endmodule

// File: rtl/writeback_pc_update.sv
// SEQ Y-86 writeback stage: commits valE/valM, selects the next PC, tracks
// sticky status with a RUN/STOP machine and keeps cycle/retire counters.
module writeback_pc_update
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_pc_update_if.slave bus
);

    state_t           r_state, w_state_next;
    stat_t            r_stat,  w_stat_next;
    logic [63:0]      r_pc,    w_pc_next;
    logic [CNT_W-1:0] r_cycle, w_cycle_next;
    logic [CNT_W-1:0] r_retire, w_retire_next;
    stat_t            w_new_stat;
    logic             w_we;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    assign w_new_stat = classify(bus.imem_error, bus.dmem_error, bus.instr_valid, bus.icode);

    always_comb begin
        w_state_next  = r_state;
        w_stat_next   = r_stat;
        w_pc_next     = r_pc;
        w_cycle_next  = r_cycle;
        w_retire_next = r_retire;
        w_we          = 1'b0;
        if (bus.en && r_state == S_RUN) begin
            w_cycle_next = (r_cycle == '1) ? r_cycle : r_cycle + CNT_ONE;
            if (w_new_stat == SAOK) begin
                w_we          = 1'b1;
                w_retire_next = (r_retire == '1) ? r_retire : r_retire + CNT_ONE;
                if (bus.icode == ICALL || (bus.icode == IJXX && bus.cnd))
                    w_pc_next = bus.valC;
                else if (bus.icode == IRET)
                    w_pc_next = bus.valM;
                else
                    w_pc_next = bus.valP;
            end else begin
                // PC stays on the faulting/halting instruction for diagnosis.
                w_stat_next  = w_new_stat;
                w_state_next = S_STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_stat   <= SAOK;
            r_pc     <= RESET_PC;
            r_cycle  <= '0;
            r_retire <= '0;
        end else begin
            r_state  <= w_state_next;
            r_stat   <= w_stat_next;
            r_pc     <= w_pc_next;
            r_cycle  <= w_cycle_next;
            r_retire <= w_retire_next;
        end
    end

    y86_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_dst_e (bus.dstE),
        .i_dst_m (bus.dstM),
        .i_val_e (bus.valE),
        .i_val_m (bus.valM),
        .i_src_a (bus.srcA),
        .i_src_b (bus.srcB),
        .o_val_a (bus.valA),
        .o_val_b (bus.valB)
    );

    assign bus.pc           = r_pc;
    assign bus.stat         = r_stat;
    assign bus.halted       = (r_state == S_STOP);
    assign bus.cycle_count  = r_cycle;
    assign bus.retire_count = r_retire;

endmodule

// File: tb/tb_writeback_pc_update.sv
// Directed bench for writeback_pc_update: expectations are queued as each
// step is driven and popped against the DUT outputs after the edge.
module tb_writeback_pc_update;
    import y86_pkg::*;

    localparam int CNT_W = 4;

    localparam int O_PC = 0, O_STAT = 1, O_HALT = 2, O_CYC = 3, O_RET = 4, O_VA = 5, O_VB = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    writeback_pc_update_if #(.CNT_W(CNT_W)) wb_if ();

    writeback_pc_update #(.RESET_PC(64'd0), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wb_if)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            O_PC:    return wb_if.pc;
            O_STAT:  return 64'(wb_if.stat);
            O_HALT:  return 64'(wb_if.halted);
            O_CYC:   return 64'(wb_if.cycle_count);
            O_RET:   return 64'(wb_if.retire_count);
            O_VA:    return wb_if.valA;
            default: return wb_if.valB;
        endcase
    endfunction

    task automatic idle_inputs();
        wb_if.en = 1'b1;          wb_if.icode = INOP;      wb_if.cnd = 1'b0;
        wb_if.instr_valid = 1'b1; wb_if.imem_error = 1'b0; wb_if.dmem_error = 1'b0;
        wb_if.dstE = RNONE;       wb_if.dstM = RNONE;
        wb_if.valE = '0; wb_if.valM = '0; wb_if.valC = '0; wb_if.valP = '0;
        wb_if.srcA = RNONE;       wb_if.srcB = RNONE;
    endtask

    // Clock one edge with the inputs currently driven, then return to idle.
    task automatic tick(input string what);
        @(posedge clk);
        #1;
        $display("step %-10s pc=%h stat=%0d halted=%0b cyc=%0d ret=%0d", what,
                 wb_if.pc, wb_if.stat, wb_if.halted, wb_if.cycle_count, wb_if.retire_count);
        idle_inputs();
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
    endtask

    task automatic read_pair(input logic [3:0] a, input logic [3:0] b);
        wb_if.srcA = a;
        wb_if.srcB = b;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick("reset");
        tick("reset");
        rst = 1'b0;

        push("rst_pc", O_PC, 64'h0);  push("rst_stat", O_STAT, 64'd1);
        push("rst_halt", O_HALT, 64'd0); push("rst_cyc", O_CYC, 64'd0);
        push("rst_ret", O_RET, 64'd0);
        read_pair(4'd2, 4'd4);
        push("rst_r2", O_VA, 64'h0);  push("rst_r4", O_VB, 64'h0);
        drain();

        // irmovq into %rdx
        wb_if.icode = IIRMOVQ; wb_if.dstE = 4'd2; wb_if.valE = 64'h1234; wb_if.valP = 64'd10;
        tick("irmovq");
        read_pair(4'd2, RNONE);
        push("wr_r2", O_VA, 64'h1234); push("wr_none", O_VB, 64'h0);
        push("wr_pc", O_PC, 64'd10);   push("wr_ret", O_RET, 64'd1);
        push("wr_cyc", O_CYC, 64'd1);
        drain();

        // popq %rsp: M port wins
        wb_if.icode = IPOPQ; wb_if.dstE = RRSP; wb_if.dstM = RRSP;
        wb_if.valE = 64'h100; wb_if.valM = 64'h55; wb_if.valP = 64'h12;
        tick("popq_rsp");
        read_pair(RRSP, 4'd2);
        push("prio_rsp", O_VA, 64'h55); push("prio_r2", O_VB, 64'h1234);
        push("prio_pc", O_PC, 64'h12);  push("prio_ret", O_RET, 64'd2);
        drain();

        wb_if.icode = IJXX; wb_if.cnd = 1'b1; wb_if.valC = 64'h40; wb_if.valP = 64'h9;
        tick("jxx_taken");
        push("jxx_taken_pc", O_PC, 64'h40);
        drain();

        wb_if.icode = IJXX; wb_if.cnd = 1'b0; wb_if.valC = 64'h40; wb_if.valP = 64'h9;
        tick("jxx_fall");
        push("jxx_fall_pc", O_PC, 64'h9);
        drain();

        wb_if.icode = ICALL; wb_if.valC = 64'h80; wb_if.valP = 64'h1a;
        wb_if.dstE = RRSP; wb_if.valE = 64'h4f;
        tick("call");
        read_pair(RRSP, RNONE);
        push("call_pc", O_PC, 64'h80); push("call_rsp", O_VA, 64'h4f);
        drain();

        wb_if.icode = IRET; wb_if.valM = 64'h13; wb_if.valP = 64'h81;
        tick("ret");
        push("ret_pc", O_PC, 64'h13); push("ret_ret", O_RET, 64'd6);
        push("ret_cyc", O_CYC, 64'd6);
        drain();

        wb_if.icode = IJXX; wb_if.cnd = 1'b1; wb_if.valC = 64'h20; wb_if.valP = 64'h14;
        tick("jmp_0x20");

        // halt at 0x20, then attempted writes while stopped
        wb_if.icode = IHALT; wb_if.valP = 64'h21;
        tick("halt");
        push("hlt_stat", O_STAT, 64'd2); push("hlt_halt", O_HALT, 64'd1);
        push("hlt_pc", O_PC, 64'h20);    push("hlt_cyc", O_CYC, 64'd8);
        push("hlt_ret", O_RET, 64'd7);
        drain();
        for (int i = 0; i < 5; i++) begin
            wb_if.icode = IIRMOVQ; wb_if.dstE = 4'd1; wb_if.valE = 64'hdead; wb_if.valP = 64'h99;
            tick("stopped");
        end
        read_pair(4'd1, RRSP);
        push("stop_r1", O_VA, 64'h0);    push("stop_rsp", O_VB, 64'h4f);
        push("stop_pc", O_PC, 64'h20);   push("stop_cyc", O_CYC, 64'd8);
        push("stop_ret", O_RET, 64'd7);  push("stop_stat", O_STAT, 64'd2);
        drain();

        // reset out of STOP with a competing write
        rst = 1'b1; wb_if.icode = IIRMOVQ; wb_if.dstE = 4'd2; wb_if.valE = 64'hbeef;
        tick("rst_stop");
        rst = 1'b0;
        read_pair(4'd2, RRSP);
        push("rs_stat", O_STAT, 64'd1); push("rs_halt", O_HALT, 64'd0);
        push("rs_pc", O_PC, 64'h0);     push("rs_cyc", O_CYC, 64'd0);
        push("rs_ret", O_RET, 64'd0);   push("rs_r2", O_VA, 64'h0);
        push("rs_rsp", O_VB, 64'h0);
        drain();

        // ADR outranks INS
        wb_if.icode = IIRMOVQ; wb_if.dmem_error = 1'b1; wb_if.instr_valid = 1'b0;
        wb_if.dstE = 4'd5; wb_if.valE = 64'h77; wb_if.valP = 64'h8;
        tick("dmem_err");
        read_pair(4'd5, RNONE);
        push("adr_stat", O_STAT, 64'd3); push("adr_r5", O_VA, 64'h0);
        push("adr_ret", O_RET, 64'd0);   push("adr_pc", O_PC, 64'h0);
        push("adr_cyc", O_CYC, 64'd1);
        drain();

        do_reset();
        wb_if.icode = IIRMOVQ; wb_if.instr_valid = 1'b0;
        wb_if.dstE = 4'd5; wb_if.valE = 64'h77; wb_if.valP = 64'h8;
        tick("ins");
        read_pair(4'd5, RNONE);
        push("ins_stat", O_STAT, 64'd4); push("ins_r5", O_VA, 64'h0);
        push("ins_ret", O_RET, 64'd0);   push("ins_halt", O_HALT, 64'd1);
        drain();

        // INS outranks HLT; imem_error alone gives ADR
        do_reset();
        wb_if.icode = IHALT; wb_if.instr_valid = 1'b0;
        tick("halt_ins");
        push("hins_stat", O_STAT, 64'd4);
        drain();
        do_reset();
        wb_if.icode = INOP; wb_if.imem_error = 1'b1;
        tick("imem_err");
        push("imem_stat", O_STAT, 64'd3);
        drain();

        // enable low holds everything
        do_reset();
        wb_if.icode = IIRMOVQ; wb_if.dstE = 4'd3; wb_if.valE = 64'h33; wb_if.valP = 64'd5;
        tick("irmovq_r3");
        for (int i = 0; i < 3; i++) begin
            wb_if.en = 1'b0; wb_if.icode = IIRMOVQ; wb_if.dstE = 4'd3;
            wb_if.valE = 64'hbad; wb_if.valP = 64'h77;
            tick("en_low");
        end
        read_pair(4'd3, RNONE);
        push("en_r3", O_VA, 64'h33); push("en_pc", O_PC, 64'd5);
        push("en_cyc", O_CYC, 64'd1); push("en_ret", O_RET, 64'd1);
        drain();

        // counters saturate at all-ones
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wb_if.icode = INOP; wb_if.valP = 64'(i + 1);
            tick("nop");
        end
        push("sat_cyc", O_CYC, 64'd15); push("sat_ret", O_RET, 64'd15);
        push("sat_pc", O_PC, 64'd18);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
